// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encoding, register write-select codes
// and the destination-register decode used by WB, forwarding and hazard logic.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALTED   = 2'b10
    } pipe_state_e;

    localparam logic [1:0] WRSEL_RT = 2'b00;
    localparam logic [1:0] WRSEL_RD = 2'b01;
    localparam logic [1:0] WRSEL_RS = 2'b10;
    localparam logic [1:0] WRSEL_R7 = 2'b11;
    localparam logic [2:0] RET_REG  = 3'd7;

    function automatic logic [2:0] dest_reg(input logic [15:0] instr, input logic [1:0] wr_sel);
        logic [2:0] d;
        case (wr_sel)
            WRSEL_RT: d = instr[7:5];
            WRSEL_RD: d = instr[4:2];
            WRSEL_RS: d = instr[10:8];
            WRSEL_R7: d = RET_REG;
            default:  d = RET_REG;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: a load in EX whose destination is read by the
// instruction in ID cannot be covered by forwarding and needs one bubble.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [15:0] idex_instr,
    input  logic        idex_wr_en,
    input  logic [1:0]  idex_wr_sel,
    input  logic        idex_mem_read,
    output logic        hazard
);

    logic [2:0] dest_s;
    logic       unused_bits_s;

    assign dest_s = dest_reg(idex_instr, idex_wr_sel);
    assign hazard = idex_mem_read & idex_wr_en &
                    ((id_rs_used & (dest_s == id_rs)) | (id_rt_used & (dest_s == id_rt)));

    // Opcode/function bits outside the register fields play no part in the compare.
    assign unused_bits_s = &{1'b0, idex_instr[15:11], idex_instr[1:0]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (RUN / MEM_WAIT / HALTED).
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      id_instr,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [15:0]      idex_instr,
    input  logic             idex_wr_en,
    input  logic [1:0]       idex_wr_sel,
    input  logic             idex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_done,
    input  logic             halt_wb,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_ONE   = {{(WCNT_W-1){1'b0}}, 1'b1};

    pipe_state_e       state_r, state_nxt_s;
    logic [WCNT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic              mem_timeout_r, timeout_set_s;
    logic              hazard_s, miss_s;
    logic              pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s;
    logic              ifid_flush_s, idex_bubble_s, memwb_bubble_s;
    logic              unused_bits_s;

    load_use_detect u_load_use_detect (
        .id_rs         (id_instr[10:8]),
        .id_rt         (id_instr[7:5]),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .idex_instr    (idex_instr),
        .idex_wr_en    (idex_wr_en),
        .idex_wr_sel   (idex_wr_sel),
        .idex_mem_read (idex_mem_read),
        .hazard        (hazard_s)
    );

    assign miss_s        = dmem_req & ~dmem_done;
    assign unused_bits_s = &{1'b0, id_instr[15:11], id_instr[4:0]};

    // Next-state and zero-latency stall/flush decode.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        timeout_set_s  = 1'b0;
        pc_we_s        = 1'b1;
        ifid_we_s      = 1'b1;
        idex_we_s      = 1'b1;
        exmem_we_s     = 1'b1;
        memwb_we_s     = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        memwb_bubble_s = 1'b0;
        case (state_r)
            RUN: begin
                if (halt_wb) begin
                    {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s} = 5'b00000;
                    state_nxt_s = HALTED;
                end else if (miss_s) begin
                    {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s} = 4'b0000;
                    memwb_bubble_s = 1'b1;
                    wait_cnt_nxt_s = WAIT_ONE;
                    state_nxt_s    = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else if (hazard_s) begin
                    // IF/ID is held here, so a pending fetch simply retries.
                    pc_we_s       = 1'b0;
                    ifid_we_s     = 1'b0;
                    idex_bubble_s = 1'b1;
                end else if (!imem_ready) begin
                    pc_we_s      = 1'b0;
                    ifid_flush_s = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_done) begin
                    wait_cnt_nxt_s = {WCNT_W{1'b0}};
                    state_nxt_s    = RUN;
                end else begin
                    {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s} = 4'b0000;
                    memwb_bubble_s = 1'b1;
                    if (wait_cnt_r == WAIT_LIMIT) begin
                        timeout_set_s = 1'b1;
                        state_nxt_s   = HALTED;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
                    end
                end
            end
            HALTED: begin
                {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s} = 5'b00000;
            end
            default: begin
                {pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s} = 5'b00000;
                state_nxt_s = HALTED;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RUN;
            wait_cnt_r    <= {WCNT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_r | timeout_set_s;
        end
    end

    // Controls are forced inactive for the whole time reset is held.
    assign pc_we        = rst_n & pc_we_s;
    assign ifid_we      = rst_n & ifid_we_s;
    assign idex_we      = rst_n & idex_we_s;
    assign exmem_we     = rst_n & exmem_we_s;
    assign memwb_we     = rst_n & memwb_we_s;
    assign ifid_flush   = rst_n & ifid_flush_s;
    assign idex_bubble  = rst_n & idex_bubble_s;
    assign memwb_bubble = rst_n & memwb_bubble_s;
    assign halted       = (state_r == HALTED);
    assign mem_timeout  = mem_timeout_r;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic             stall_inc_s, flush_inc_s;

    assign stall_inc_s = (state_r != HALTED) & ~pc_we_s;
    assign flush_inc_s = (state_r == RUN) & ~halt_wb & ~miss_s & ex_branch_taken;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle RUN vectors
// plus hand-written miss, timeout, halt and reset sequences.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TO    = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [15:0]      id_instr;
    logic             id_rs_used, id_rt_used;
    logic [15:0]      idex_instr;
    logic             idex_wr_en;
    logic [1:0]       idex_wr_sel;
    logic             idex_mem_read;
    logic             ex_branch_taken, imem_ready, dmem_req, dmem_done, halt_wb;
    logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic             ifid_flush, idex_bubble, memwb_bubble, halted, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_instr(id_instr), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .idex_instr(idex_instr), .idex_wr_en(idex_wr_en), .idex_wr_sel(idex_wr_sel),
        .idex_mem_read(idex_mem_read), .ex_branch_taken(ex_branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_done(dmem_done),
        .halt_wb(halt_wb),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .memwb_bubble(memwb_bubble), .halted(halted), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, memwb_bubble}
    localparam logic [7:0] O_RUN    = 8'b11111_000;
    localparam logic [7:0] O_LU     = 8'b00111_010;
    localparam logic [7:0] O_BR     = 8'b11111_110;
    localparam logic [7:0] O_IMEM   = 8'b01111_100;
    localparam logic [7:0] O_FREEZE = 8'b00001_001;
    localparam logic [7:0] O_NONE   = 8'b00000_000;

    typedef struct {
        string       name;
        logic [15:0] id_instr;
        logic        rs_used, rt_used;
        logic [15:0] idex_instr;
        logic        wr_en;
        logic [1:0]  wr_sel;
        logic        mem_read, br, imem_rdy, dreq, ddone;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] mk(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        return {5'b00000, rs, rt, rd, 2'b00};
    endfunction

    function automatic logic [7:0] outs();
        return {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, memwb_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_perf(input string name);
`ifdef PIPE_PERF_CNT_EN
        check({name, "_stall"}, 32'(stall_cycles), 32'(exp_stall));
        check({name, "_flush"}, 32'(flush_count), 32'(exp_flush));
`else
        check({name, "_perf_tied"}, {16'(stall_cycles), 16'(flush_count)}, 32'h0);
`endif
    endtask

    task automatic idle();
        id_instr = 16'h0000; id_rs_used = 1'b0; id_rt_used = 1'b0;
        idex_instr = 16'h0000; idex_wr_en = 1'b0; idex_wr_sel = 2'b00; idex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_done = 1'b0;
        halt_wb = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_outs", 32'(outs()), 32'(O_NONE));
        check("rst_flags", {halted, mem_timeout}, 32'h0);
        exp_stall = 0;
        exp_flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input string n, input logic [15:0] idi, input logic rsu, input logic rtu,
                       input logic [15:0] exi, input logic wen, input logic [1:0] ws, input logic mr,
                       input logic br, input logic imr, input logic dq, input logic dd,
                       input logic [7:0] e);
        vec_t v;
        v.name = n; v.id_instr = idi; v.rs_used = rsu; v.rt_used = rtu; v.idex_instr = exi;
        v.wr_en = wen; v.wr_sel = ws; v.mem_read = mr; v.br = br; v.imem_rdy = imr;
        v.dreq = dq; v.ddone = dd; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        //   name            id_instr       rsu   rtu   idex_instr     wen   sel    mr    br    imr   dq    dd    exp
        add("idle",          mk(0,0,0),     1'b0, 1'b0, mk(0,0,0),     1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
        add("lu_rs_rt",      mk(3,1,0),     1'b1, 1'b0, mk(0,3,0),     1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_LU);
        add("lu_rt_rd",      mk(0,5,0),     1'b0, 1'b1, mk(0,0,5),     1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_LU);
        add("nolu_rtunused", mk(0,5,0),     1'b0, 1'b0, mk(0,0,5),     1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
        add("nolu_noload",   mk(3,1,0),     1'b1, 1'b0, mk(0,3,0),     1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
        add("nolu_nowr",     mk(3,1,0),     1'b1, 1'b0, mk(0,3,0),     1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
        add("nolu_wrongsel", mk(3,1,0),     1'b1, 1'b0, mk(0,3,0),     1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
        add("lu_rs_rs",      mk(4,0,0),     1'b1, 1'b0, mk(4,0,0),     1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_LU);
        add("lu_r7",         mk(0,7,0),     1'b0, 1'b1, mk(1,2,3),     1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_LU);
        add("nolu_r7_unused",mk(0,7,0),     1'b0, 1'b0, mk(1,2,3),     1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN);
        add("br_over_lu",    mk(3,1,0),     1'b1, 1'b0, mk(0,3,0),     1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_BR);
        add("imem_wait",     mk(0,0,0),     1'b0, 1'b0, mk(0,0,0),     1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IMEM);
        add("lu_over_imem",  mk(3,1,0),     1'b1, 1'b0, mk(0,3,0),     1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
        add("br_over_imem",  mk(0,0,0),     1'b0, 1'b0, mk(0,0,0),     1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_BR);
        add("dmem_hit",      mk(0,0,0),     1'b0, 1'b0, mk(0,0,0),     1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_RUN);
        add("lu_with_hit",   mk(3,1,0),     1'b1, 1'b0, mk(0,3,0),     1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, O_LU);

        #2;
        check("rst_outs", 32'(outs()), 32'(O_NONE));
        check("rst_flags", {halted, mem_timeout}, 32'h0);
        check_perf("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle RUN vectors; none changes state.
        foreach (vecs[i]) begin
            @(negedge clk);
            id_instr = vecs[i].id_instr; id_rs_used = vecs[i].rs_used; id_rt_used = vecs[i].rt_used;
            idex_instr = vecs[i].idex_instr; idex_wr_en = vecs[i].wr_en; idex_wr_sel = vecs[i].wr_sel;
            idex_mem_read = vecs[i].mem_read; ex_branch_taken = vecs[i].br;
            imem_ready = vecs[i].imem_rdy; dmem_req = vecs[i].dreq; dmem_done = vecs[i].ddone;
            #1;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            if (!vecs[i].exp[7]) exp_stall++;
            if (vecs[i].br) exp_flush++;
        end
        @(negedge clk);
        idle();
        #1;
        check("after_table_outs", 32'(outs()), 32'(O_RUN));
        check_perf("table");

        // Load-use releases once the load has moved on: bubble lasts one cycle.
        @(negedge clk);
        id_instr = mk(3,1,0); id_rs_used = 1'b1;
        idex_instr = mk(0,3,0); idex_wr_en = 1'b1; idex_mem_read = 1'b1;
        #1 check("lu_cycle1", 32'(outs()), 32'(O_LU));
        exp_stall++;
        @(negedge clk);
        idex_instr = 16'h0000; idex_wr_en = 1'b0; idex_mem_read = 1'b0;
        #1 check("lu_cycle2", 32'(outs()), 32'(O_RUN));

        // Memory miss: three frozen cycles, branch/imem ignored while waiting.
        @(negedge clk);
        idle(); dmem_req = 1'b1;
        #1 check("miss_run", 32'(outs()), 32'(O_FREEZE));
        exp_stall++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ex_branch_taken = 1'b1; imem_ready = 1'b0;
            #1 check("miss_wait", 32'(outs()), 32'(O_FREEZE));
            exp_stall++;
        end
        @(negedge clk);
        dmem_done = 1'b1;
        #1 check("miss_done", 32'(outs()), 32'(O_RUN));
        @(negedge clk);
        idle();
        #1 check("miss_back_run", 32'(outs()), 32'(O_RUN));
        check("miss_flags", {halted, mem_timeout}, 32'h0);
        check_perf("miss");

        // Halt: enables drop at once, halted follows on the next edge.
        @(negedge clk);
        halt_wb = 1'b1;
        #1 check("halt_run", 32'(outs()), 32'(O_NONE));
        check("halt_not_yet", 32'(halted), 32'h0);
        exp_stall++;
        @(negedge clk);
        idle();
        #1 check("halted_outs", 32'(outs()), 32'(O_NONE));
        check("halted_flag", 32'(halted), 32'h1);
        @(negedge clk);
        #1 check_perf("halt");
        @(posedge clk);
        do_reset();
        #1 check("post_halt_reset", {halted, 8'(outs())}, 32'(O_RUN));

        // Timeout after TO wait cycles; sticky until reset.
        @(negedge clk);
        dmem_req = 1'b1;
        #1 check("to_run", 32'(outs()), 32'(O_FREEZE));
        exp_stall++;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            #1 check("to_wait", {halted, mem_timeout, 8'(outs())}, 32'(O_FREEZE));
            exp_stall++;
        end
        @(negedge clk);
        #1 check("to_fault", {halted, mem_timeout, 8'(outs())}, {24'h0, 2'b11, O_NONE});
        @(negedge clk);
        dmem_done = 1'b1;
        #1 check("to_held", {halted, mem_timeout, 8'(outs())}, {24'h0, 2'b11, O_NONE});
        @(negedge clk);
        #1 check("to_held2", {halted, mem_timeout}, 32'h3);
        check_perf("timeout");
        @(posedge clk);
        do_reset();
        #1 check("to_reset", {halted, mem_timeout, 8'(outs())}, 32'(O_RUN));

        // Reset in the middle of a wait abandons it.
        idle();
        @(negedge clk);
        dmem_req = 1'b1;
        @(negedge clk);
        #1 check("abort_wait", 32'(outs()), 32'(O_FREEZE));
        @(posedge clk);
        do_reset();
        idle();
        #1 check("abort_run", 32'(outs()), 32'(O_RUN));
        @(negedge clk);
        #1 check("abort_run2", {halted, mem_timeout, 8'(outs())}, 32'(O_RUN));
        check_perf("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
